// File: rtl/alu_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// alu_ctrl_pkg
// Shared definitions for the ALU operation sequencer:
//   - opcode codes understood by the external ALU
//   - PSR bit positions and the default per-class flag masks
//   - controller state encoding
//   - classify_op(): legality, write-back enable and flag-mask class of an opcode
// -----------------------------------------------------------------------------
package alu_ctrl_pkg;

    localparam int OP_W = 4;

    localparam logic [OP_W-1:0] OP_AND = 4'b0001;
    localparam logic [OP_W-1:0] OP_OR  = 4'b0010;
    localparam logic [OP_W-1:0] OP_XOR = 4'b0011;
    localparam logic [OP_W-1:0] OP_ADD = 4'b0101;
    localparam logic [OP_W-1:0] OP_SUB = 4'b1001;
    localparam logic [OP_W-1:0] OP_CMP = 4'b1011;
    localparam logic [OP_W-1:0] OP_MOV = 4'b1101;
    localparam logic [OP_W-1:0] OP_LUI = 4'b1111;

    localparam int PSR_C = 0;
    localparam int PSR_L = 2;
    localparam int PSR_F = 5;
    localparam int PSR_Z = 6;
    localparam int PSR_N = 7;

    // Default masks are built from the bit positions so the two stay in sync.
    localparam logic [15:0] ARITH_MASK_DEFAULT = 16'((1 << PSR_C) | (1 << PSR_F));
    localparam logic [15:0] CMP_MASK_DEFAULT   = 16'((1 << PSR_L) | (1 << PSR_Z) | (1 << PSR_N));

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } state_e;

    // Which PSR mask an opcode applies in write-back.
    typedef enum logic [1:0] {
        FM_NONE  = 2'd0,
        FM_ARITH = 2'd1,
        FM_CMP   = 2'd2
    } flag_sel_e;

    typedef struct packed {
        logic      legal;
        logic      wr_en;
        flag_sel_e flag_sel;
    } op_class_t;

    function automatic op_class_t classify_op(input logic [OP_W-1:0] op);
        op_class_t c;
        c = '{legal: 1'b1, wr_en: 1'b1, flag_sel: FM_NONE};
        case (op)
            OP_AND, OP_OR, OP_XOR, OP_MOV, OP_LUI: ;
            OP_ADD, OP_SUB: c.flag_sel = FM_ARITH;
            OP_CMP: begin
                c.wr_en    = 1'b0;
                c.flag_sel = FM_CMP;
            end
            default: begin
                c.legal = 1'b0;
                c.wr_en = 1'b0;
            end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer
// Multi-cycle controller executing one register/immediate ALU instruction per
// accepted start: IDLE -> READ -> EXEC -> WB -> IDLE.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   start               execute request, sampled only in IDLE
//   opcode/rdest/rsrc/imm/use_imm   decoded instruction fields
//   busy                high in every state but IDLE
//   done, illegal       one-cycle pulses in WB (illegal only for unknown opcodes)
//   rf_raddr_a/b, rf_rdata_a/b      asynchronous-read register file ports
//   rf_we/waddr/wdata   register file write port, pulses in WB
//   alu_a/b/sel, alu_y, alu_flags   external ALU interface
//   psr                 processor status register
// -----------------------------------------------------------------------------
module alu_op_sequencer
    import alu_ctrl_pkg::*;
#(
    parameter int                DATA_W          = 16,
    parameter int                RADDR_W         = 4,
    parameter logic [DATA_W-1:0] ARITH_FLAG_MASK = DATA_W'(ARITH_MASK_DEFAULT),
    parameter logic [DATA_W-1:0] CMP_FLAG_MASK   = DATA_W'(CMP_MASK_DEFAULT)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [OP_W-1:0]    opcode,
    input  logic [RADDR_W-1:0] rdest,
    input  logic [RADDR_W-1:0] rsrc,
    input  logic [DATA_W-1:0]  imm,
    input  logic               use_imm,
    output logic               busy,
    output logic               done,
    output logic               illegal,
    output logic [RADDR_W-1:0] rf_raddr_a,
    output logic [RADDR_W-1:0] rf_raddr_b,
    input  logic [DATA_W-1:0]  rf_rdata_a,
    input  logic [DATA_W-1:0]  rf_rdata_b,
    output logic               rf_we,
    output logic [RADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0]  rf_wdata,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    output logic [OP_W-1:0]    alu_sel,
    input  logic [DATA_W-1:0]  alu_y,
    input  logic [DATA_W-1:0]  alu_flags,
    output logic [DATA_W-1:0]  psr
);

    state_e              state_q,   state_d;
    logic [OP_W-1:0]     op_q,      op_d;
    logic [RADDR_W-1:0]  rdest_q,   rdest_d;
    logic [RADDR_W-1:0]  rsrc_q,    rsrc_d;
    logic [DATA_W-1:0]   imm_q,     imm_d;
    logic                use_imm_q, use_imm_d;
    logic [DATA_W-1:0]   alu_a_q,   alu_a_d;
    logic [DATA_W-1:0]   alu_b_q,   alu_b_d;
    logic [OP_W-1:0]     alu_sel_q, alu_sel_d;
    logic [DATA_W-1:0]   result_q,  result_d;
    logic [DATA_W-1:0]   flags_q,   flags_d;
    logic [DATA_W-1:0]   psr_q,     psr_d;

    op_class_t           op_class;
    logic [DATA_W-1:0]   flag_mask;

    // Read addresses come straight from the latched instruction; the register
    // file only matters in READ, and the write address is the same rdest.
    assign rf_raddr_a = rdest_q;
    assign rf_raddr_b = rsrc_q;
    assign rf_waddr   = rdest_q;
    assign rf_wdata   = result_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_sel    = alu_sel_q;
    assign psr        = psr_q;

    // NOTE: every signal written here gets a default before the case so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        rdest_d   = rdest_q;
        rsrc_d    = rsrc_q;
        imm_d     = imm_q;
        use_imm_d = use_imm_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_sel_d = alu_sel_q;
        result_d  = result_q;
        flags_d   = flags_q;
        psr_d     = psr_q;

        busy      = (state_q != ST_IDLE);
        done      = 1'b0;
        illegal   = 1'b0;
        rf_we     = 1'b0;

        op_class  = classify_op(op_q);
        case (op_class.flag_sel)
            FM_ARITH: flag_mask = ARITH_FLAG_MASK;
            FM_CMP:   flag_mask = CMP_FLAG_MASK;
            default:  flag_mask = '0;
        endcase

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d      = opcode;
                    rdest_d   = rdest;
                    rsrc_d    = rsrc;
                    imm_d     = imm;
                    use_imm_d = use_imm;
                    state_d   = ST_READ;
                end
            end
            ST_READ: begin
                alu_a_d   = rf_rdata_a;
                alu_b_d   = use_imm_q ? imm_q : rf_rdata_b;
                alu_sel_d = op_q;
                state_d   = ST_EXEC;
            end
            ST_EXEC: begin
                result_d = alu_y;
                flags_d  = alu_flags;
                state_d  = ST_WB;
            end
            ST_WB: begin
                done    = 1'b1;
                illegal = ~op_class.legal;
                rf_we   = op_class.wr_en;
                // Only the masked bits follow the ALU; a zero mask keeps psr.
                psr_d   = (psr_q & ~flag_mask) | (flags_q & flag_mask);
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the values from before this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the datapath registers are reset too, because they drive
            // alu_*, rf_w* and psr directly and those must read zero in reset.
            state_q   <= ST_IDLE;
            op_q      <= '0;
            rdest_q   <= '0;
            rsrc_q    <= '0;
            imm_q     <= '0;
            use_imm_q <= 1'b0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_sel_q <= '0;
            result_q  <= '0;
            flags_q   <= '0;
            psr_q     <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            rdest_q   <= rdest_d;
            rsrc_q    <= rsrc_d;
            imm_q     <= imm_d;
            use_imm_q <= use_imm_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_sel_q <= alu_sel_d;
            result_q  <= result_d;
            flags_q   <= flags_d;
            psr_q     <= psr_d;
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_op_sequencer
// Surrounds the sequencer with a behavioural register file and ALU, drives
// directed and random instructions, and compares every cycle of each
// instruction against expectations derived from the instruction semantics.
// -----------------------------------------------------------------------------
module tb_alu_op_sequencer;
    import alu_ctrl_pkg::*;

    localparam int DW = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [3:0]    opcode;
    logic [AW-1:0] rdest, rsrc;
    logic [DW-1:0] imm;
    logic          use_imm;
    logic          busy, done, illegal;
    logic [AW-1:0] rf_raddr_a, rf_raddr_b, rf_waddr;
    logic [DW-1:0] rf_rdata_a, rf_rdata_b, rf_wdata;
    logic          rf_we;
    logic [DW-1:0] alu_a, alu_b, alu_y, alu_flags, psr;
    logic [3:0]    alu_sel;

    always #5 clk = ~clk;

    alu_op_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .opcode(opcode), .rdest(rdest),
        .rsrc(rsrc), .imm(imm), .use_imm(use_imm), .busy(busy), .done(done),
        .illegal(illegal), .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
        .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b), .rf_we(rf_we),
        .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .alu_a(alu_a), .alu_b(alu_b),
        .alu_sel(alu_sel), .alu_y(alu_y), .alu_flags(alu_flags), .psr(psr)
    );

    // ---------------- external ALU behaviour ----------------
    function automatic logic [DW-1:0] alu_fn_y(input logic [3:0] sel, input logic [DW-1:0] a, input logic [DW-1:0] b);
        case (sel)
            OP_AND:         return a & b;
            OP_OR:          return a | b;
            OP_XOR:         return a ^ b;
            OP_ADD:         return a + b;
            OP_SUB, OP_CMP: return a - b;
            OP_MOV:         return b;
            OP_LUI:         return b << 8;
            default:        return ~a;
        endcase
    endfunction

    // Full flag vector for every op; the unmasked bits carry data-dependent
    // noise so any masking error shows up in psr.
    function automatic logic [DW-1:0] alu_fn_flags(input logic [3:0] sel, input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [16:0]   sum, dif;
        logic [DW-1:0] y, fl;
        logic          c, f;
        sum = {1'b0, a} + {1'b0, b};
        dif = {1'b0, a} + {1'b0, ~b} + 17'd1;
        if (sel == OP_SUB || sel == OP_CMP) begin
            c = dif[16];
            f = (a[15] != b[15]) && (dif[15] != a[15]);
        end else begin
            c = sum[16];
            f = (a[15] == b[15]) && (sum[15] != a[15]);
        end
        y = alu_fn_y(sel, a, b);
        fl          = '0;
        fl[15:8]    = y[7:0] ^ a[7:0];
        fl[PSR_N]   = ($signed(a) < $signed(b));
        fl[PSR_Z]   = (a == b);
        fl[PSR_F]   = f;
        fl[4]       = ^y;
        fl[3]       = y[0];
        fl[PSR_L]   = (a < b);
        fl[1]       = y[15];
        fl[PSR_C]   = c;
        return fl;
    endfunction

    logic [DW-1:0] flag_force = '0;
    assign alu_y     = alu_fn_y(alu_sel, alu_a, alu_b);
    assign alu_flags = alu_fn_flags(alu_sel, alu_a, alu_b) | flag_force;

    // ---------------- register file ----------------
    logic [DW-1:0] rf [16];
    logic          pre_we = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [DW-1:0] pre_data = '0;
    int            we_pulses = 0;

    always @(posedge clk) begin
        if (rf_we) begin
            rf[rf_waddr] <= rf_wdata;
            we_pulses    <= we_pulses + 1;
        end else if (pre_we) begin
            rf[pre_addr] <= pre_data;
        end
    end
    assign rf_rdata_a = rf[rf_raddr_a];
    assign rf_rdata_b = rf[rf_raddr_b];

    // ---------------- reference state and checking ----------------
    logic [DW-1:0] ref_rf [16];
    logic [DW-1:0] ref_psr = '0;
    int            exp_we  = 0;
    int            total   = 0;
    int            bad     = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        pre_we   = 1'b1;
        pre_addr = addr;
        pre_data = data;
        @(posedge clk); #1;
        pre_we   = 1'b0;
        ref_rf[addr] = data;
    endtask

    // Junk on the instruction inputs while busy; start either held or random.
    task automatic scramble(input logic hold);
        start   = hold ? 1'b1 : 1'($urandom_range(0, 1));
        opcode  = 4'($urandom);
        rdest   = 4'($urandom);
        rsrc    = 4'($urandom);
        imm     = 16'($urandom);
        use_imm = 1'($urandom);
    endtask

    // Called in IDLE at posedge+1; returns in IDLE at posedge+1, so two
    // consecutive held calls issue one instruction every 4 cycles.
    task automatic run_instr(input logic [3:0] op, input logic [AW-1:0] rd, input logic [AW-1:0] rs,
                             input logic [DW-1:0] im, input logic ui, input logic hold);
        logic [DW-1:0] a, b, y, fl, m, new_psr;
        logic          legal, we;
        a = ref_rf[rd];
        b = ui ? im : ref_rf[rs];
        y  = alu_fn_y(op, a, b);
        fl = alu_fn_flags(op, a, b) | flag_force;
        legal = (op == OP_AND) || (op == OP_OR) || (op == OP_XOR) || (op == OP_ADD) ||
                (op == OP_SUB) || (op == OP_CMP) || (op == OP_MOV) || (op == OP_LUI);
        we = legal && (op != OP_CMP);
        if (op == OP_ADD || op == OP_SUB) m = 16'h0021;
        else if (op == OP_CMP)            m = 16'h00C4;
        else                              m = 16'h0000;
        new_psr = (ref_psr & ~m) | (fl & m);

        start = 1'b1; opcode = op; rdest = rd; rsrc = rs; imm = im; use_imm = ui;
        @(posedge clk); #1;
        check("read_busy", busy, 1);
        check("read_done", done, 0);
        check("read_we", rf_we, 0);
        check("raddr_a", rf_raddr_a, rd);
        check("raddr_b", rf_raddr_b, rs);
        scramble(hold);
        @(posedge clk); #1;
        check("exec_busy", busy, 1);
        check("exec_done", done, 0);
        check("exec_we", rf_we, 0);
        check("alu_a", alu_a, a);
        check("alu_b", alu_b, b);
        check("alu_sel", alu_sel, op);
        scramble(hold);
        @(posedge clk); #1;
        check("wb_done", done, 1);
        check("wb_busy", busy, 1);
        check("wb_illegal", illegal, !legal);
        check("wb_we", rf_we, we);
        if (we) begin
            check("wb_waddr", rf_waddr, rd);
            check("wb_wdata", rf_wdata, y);
        end
        check("wb_psr_old", psr, ref_psr);
        scramble(hold);
        @(posedge clk); #1;
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
        check("idle_illegal", illegal, 0);
        check("psr", psr, new_psr);
        ref_psr = new_psr;
        if (we) begin
            ref_rf[rd] = y;
            exp_we++;
        end
        if (!hold) start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; opcode = '0; rdest = '0; rsrc = '0; imm = '0; use_imm = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_illegal", illegal, 0);
        check("rst_we", rf_we, 0);
        check("rst_psr", psr, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_b", alu_b, 0);
        check("rst_alu_sel", alu_sel, 0);
        check("rst_waddr", rf_waddr, 0);
        check("rst_wdata", rf_wdata, 0);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) preload(4'(i), 16'($urandom));

        // ADD overflow into the sign bit: F set, C clear.
        preload(4'd1, 16'h7FFF);
        run_instr(OP_ADD, 4'd1, 4'd0, 16'h0001, 1'b1, 1'b0);
        check("add_psr_const", psr, 16'h0020);

        // SUB 0-1 clears C and F; CMP 3 vs 5 sets L and N only.
        preload(4'd2, 16'h0000);
        preload(4'd3, 16'h0001);
        run_instr(OP_SUB, 4'd2, 4'd3, 16'h1234, 1'b0, 1'b0);
        check("sub_wdata_const", rf[2], 16'hFFFF);
        check("sub_psr_const", psr, 16'h0000);
        preload(4'd4, 16'h0003);
        preload(4'd5, 16'h0005);
        run_instr(OP_CMP, 4'd4, 4'd5, 16'h0000, 1'b0, 1'b0);
        check("cmp_psr_const", psr, 16'h0084);
        check("cmp_no_write", rf[4], 16'h0003);

        // Build psr = 00E5: ADD 8000+8000 sets C and F, forced CMP sets L/Z/N.
        preload(4'd6, 16'h8000);
        preload(4'd7, 16'h8000);
        run_instr(OP_ADD, 4'd6, 4'd7, 16'h0000, 1'b0, 1'b0);
        check("add_cf_psr_const", psr, 16'h00A5);
        flag_force = 16'hFFFF;
        run_instr(OP_CMP, 4'd4, 4'd5, 16'h0000, 1'b0, 1'b0);
        flag_force = 16'h0000;
        check("psr_e5_const", psr, 16'h00E5);
        run_instr(OP_XOR, 4'd8, 4'd9, 16'h0000, 1'b0, 1'b0);
        run_instr(OP_LUI, 4'd10, 4'd0, 16'h00AB, 1'b1, 1'b0);
        check("lui_rf_const", rf[10], 16'hAB00);
        check("lui_psr_const", psr, 16'h00E5);

        // start held high: back-to-back every 4 cycles, pulses while busy dropped.
        run_instr(OP_MOV, 4'd12, 4'd13, 16'h0000, 1'b0, 1'b1);
        run_instr(OP_OR,  4'd13, 4'd12, 16'h5A5A, 1'b1, 1'b1);
        run_instr(OP_SUB, 4'd14, 4'd1,  16'h0000, 1'b0, 1'b1);
        start = 1'b0;

        // Illegal opcode and rdest==rsrc.
        run_instr(4'b0000, 4'd3, 4'd4, 16'h0000, 1'b0, 1'b0);
        run_instr(OP_ADD, 4'd11, 4'd11, 16'h0000, 1'b0, 1'b0);

        // Reset during EXEC of an ADD abandons it.
        preload(4'd15, 16'hFFFF);
        start = 1'b1; opcode = OP_ADD; rdest = 4'd15; rsrc = 4'd15; imm = '0; use_imm = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        check("exec_before_rst", alu_sel, OP_ADD);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        ref_psr = '0;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_psr", psr, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_we", rf_we, 0);
        check("mid_rst_alu_a", alu_a, 0);
        repeat (4) @(posedge clk);
        #1;
        check("post_rst_busy", busy, 0);
        check("post_rst_writes", we_pulses, exp_we);
        check("post_rst_rf", rf[15], 16'hFFFF);

        // Random instructions.
        for (int n = 0; n < 40; n++) begin
            run_instr(4'($urandom), 4'($urandom), 4'($urandom), 16'($urandom),
                      1'($urandom), 1'($urandom));
        end
        start = 1'b0;
        @(posedge clk); #1;

        check("final_writes", we_pulses, exp_we);
        for (int i = 0; i < 16; i++) check("final_rf", rf[i], ref_rf[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Multi-cycle controller that executes one decoded register/immediate ALU instruction per start pulse. It reads operands from the register file, drives the external 16-bit ALU (A, B, 4-bit sel, Y, 16-bit flags), writes the result back, and maintains the processor status register (PSR) under per-opcode flag masks. It sits between the decode stage and the ALU/register file, and signals completion with a done pulse.

Parameters:
DATA_W, 16, datapath width of operands, result and PSR
RADDR_W, 4, register file address width
ARITH_FLAG_MASK, 16'h0021, PSR bits updated by ADD/SUB (C bit0, F bit5)
CMP_FLAG_MASK, 16'h00C4, PSR bits updated by CMP (L bit2, Z bit6, N bit7)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
start  in  1  request to execute; sampled only in IDLE
opcode  in  4  ALU select code for the instruction
rdest  in  RADDR_W  destination register and A-operand source
rsrc  in  RADDR_W  B-operand register (ignored when use_imm=1)
imm  in  DATA_W  immediate B operand
use_imm  in  1  1: B=imm, 0: B=R[rsrc]
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse in WB
illegal  out  1  one-cycle pulse with done for an unsupported opcode
rf_raddr_a  out  RADDR_W  read address A (asynchronous-read register file)
rf_raddr_b  out  RADDR_W  read address B
rf_rdata_a  in  DATA_W  read data A
rf_rdata_b  in  DATA_W  read data B
rf_we  out  1  write enable, pulse in WB only
rf_waddr  out  RADDR_W  write address
rf_wdata  out  DATA_W  write data
alu_a  out  DATA_W  ALU operand A
alu_b  out  DATA_W  ALU operand B
alu_sel  out  4  ALU select
alu_y  in  DATA_W  ALU result
alu_flags  in  DATA_W  ALU flag vector
psr  out  DATA_W  status register

Behaviour:
- Reset (any state): state=IDLE. busy, done, illegal and rf_we are 0. psr, alu_a, alu_b, alu_sel, rf_waddr and rf_wdata are 0. Any in-flight instruction is abandoned with no write and no PSR update.
- States: IDLE -> READ -> EXEC -> WB -> IDLE. Start to done is 3 cycles; back-to-back throughput is 1 instruction per 4 cycles.
- IDLE: when start=1, latch opcode, rdest, rsrc, imm and use_imm, then go to READ. When start=0, stay in IDLE.
- start is ignored while busy=1. It is not queued.
- READ: drive rf_raddr_a=rdest and rf_raddr_b=rsrc. Capture operand A from rf_rdata_a and operand B from (use_imm ? imm : rf_rdata_b). Go to EXEC.
- EXEC: alu_a, alu_b and alu_sel are registered and stable for the whole cycle. At the end of EXEC, capture alu_y and alu_flags. Go to WB.
- WB: done=1. Write-back and PSR update depend on the opcode class:
  - Legal, non-CMP (0001 AND, 0010 OR, 0011 XOR, 0101 ADD, 1001 SUB, 1101 MOV, 1111 LUI): rf_we=1, rf_waddr=rdest, rf_wdata=captured result.
  - CMP (1011): rf_we=0.
  - PSR update: psr <= (psr & ~M) | (flags & M).
  - M=ARITH_FLAG_MASK for 0101 and 1001. M=CMP_FLAG_MASK for 1011. M=0 for all other opcodes (psr unchanged).
  - Illegal opcode (any other code): rf_we=0, psr unchanged, illegal=1 together with done.
- rdest==rsrc is legal: both reads return the same register.
- A write and a new start never overlap, because start is only sampled in IDLE.
- When not in WB, rf_we=0 and done=0.

Decomposition:
- Shared package alu_ctrl_pkg holds:
  - opcode localparams (OP_AND, OP_OR, OP_XOR, OP_ADD, OP_SUB, OP_CMP, OP_MOV, OP_LUI)
  - PSR bit indices (PSR_C=0, PSR_L=2, PSR_F=5, PSR_Z=6, PSR_N=7)
  - the state encoding
  - a function returning the flag mask and write-enable class for an opcode
- No sub-module. The ALU stays external and is connected at the parent level.

Test Plan:
- ADD, R1=16'h7FFF, imm=16'h0001, use_imm=1 -> done at start+3, rf_we=1, waddr=1, wdata=16'h8000, psr[5]=1, psr[0]=0, other psr bits unchanged.
- SUB, R2=16'h0000, R3=16'h0001 -> wdata=16'hFFFF, psr[0]=0, psr[5]=0. Then CMP, R4=16'h0003, R5=16'h0005 -> rf_we=0, psr[2]=1, psr[6]=0, psr[7]=1, psr[0] and psr[5] retain their SUB values.
- XOR after setting psr=16'h00E5 via prior ops -> result written, psr stays 16'h00E5. LUI, imm=16'h00AB -> wdata=16'hAB00, psr unchanged.
- start held high continuously -> instructions accepted every 4 cycles. A start pulse in READ, EXEC or WB is dropped: no extra done, busy stays high until WB.
- opcode 4'b0000 -> done and illegal pulse together at start+3, rf_we=0, psr unchanged.
- rst asserted during EXEC of an ADD -> next cycle state=IDLE, busy=0, psr=0, no rf_we pulse ever issued for that ADD.
